rgbw_frame_decoder: RTL and testbench

Parametrised successor to the fixed seven-byte RGBW SPI dispenser. Hunts for a sync byte in the SPI receive stream, collects a configurable number of channel bytes plus a mode byte into a staging bank, and commits the whole frame atomically to the output bank. Adds a hard inter-byte timeout, error/valid strobes and an optional frame checksum. Sits between the SPI slave receiver and the colour generator / PWM stage.

---
 rtl/rgbw_pkg.sv | 15 +
 rtl/rgbw_rdy_sync.sv | 35 +++
 rtl/rgbw_frame_decoder.sv | 188 ++++++++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame decoder: state encoding and default geometry.
package rgbw_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    MODE    = 2'd2,
    CHECK   = 2'd3
  } rgbw_state_e;

  localparam int         DEF_NUM_CH    = 6;
  localparam int         DEF_DATA_W    = 8;
  localparam logic [7:0] DEF_SYNC_WORD = 8'h55;

endpackage

// File: rtl/rgbw_rdy_sync.sv
// Brings the SPI word-ready level into the clk domain and turns its rising edge into a
// single enabled-cycle word event.
module rgbw_rdy_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic rx_rdy,
  output logic word_evt
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // two-flop synchroniser followed by the edge-history flop, all gated by clk_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else if (clk_en) begin
      sync1_r <= rx_rdy;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end else begin
      sync1_r <= sync1_r;
      sync2_r <= sync2_r;
      prev_r  <= prev_r;
    end
  end

  // kept combinational so rx_data is consumed while the sender still holds it
  assign word_evt = clk_en & sync2_r & ~prev_r;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Sync-hunting RGBW frame decoder with atomic commit and inter-word timeout.
// Optional trailing XOR checksum word is enabled by defining RGBW_FRAME_CHECKSUM_EN.
module rgbw_frame_decoder
  import rgbw_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(DEF_SYNC_WORD),
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_rdy,
  output logic [NUM_CH*DATA_W-1:0] ch_out,
  output logic [DATA_W-1:0]        mode_out,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int         IDX_W    = 4;
  localparam int         TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_HUNT    = HUNT;
  localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
  localparam logic [1:0] ST_MODE    = MODE;
`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam logic [1:0] ST_CHECK   = CHECK;
`endif

  logic                     word_evt_s;
  logic [1:0]               state_r,      state_s;
  logic [IDX_W-1:0]         idx_r,        idx_s;
  logic [TMO_W-1:0]         tmo_r,        tmo_s;
  logic [NUM_CH*DATA_W-1:0] stage_r,      stage_s;
  logic [DATA_W-1:0]        mode_stage_r, mode_stage_s;
  logic [NUM_CH*DATA_W-1:0] ch_out_r;
  logic [DATA_W-1:0]        mode_out_r;
  logic                     frame_valid_r;
  logic                     frame_err_r;
  logic                     busy_r;
  logic                     commit_s;
  logic                     err_s;
`ifdef RGBW_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0]        xor_r, xor_s;
`endif

  rgbw_rdy_sync u_rdy_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .rx_rdy   (rx_rdy),
    .word_evt (word_evt_s)
  );

  // frame state machine: word events advance it, a silent line runs the timeout
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    tmo_s        = tmo_r;
    stage_s      = stage_r;
    mode_stage_s = mode_stage_r;
    commit_s     = 1'b0;
    err_s        = 1'b0;
`ifdef RGBW_FRAME_CHECKSUM_EN
    xor_s        = xor_r;
`endif
    if (word_evt_s) begin
      tmo_s = '0;
      case (state_r)
        ST_HUNT: begin
          if (rx_data == SYNC_WORD) begin
            state_s = ST_PAYLOAD;
            idx_s   = '0;
`ifdef RGBW_FRAME_CHECKSUM_EN
            xor_s   = SYNC_WORD;
`endif
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          for (int k = 0; k < NUM_CH; k++) begin
            stage_s[k*DATA_W +: DATA_W] = (idx_r == IDX_W'(k)) ? rx_data
                                                               : stage_r[k*DATA_W +: DATA_W];
          end
`ifdef RGBW_FRAME_CHECKSUM_EN
          xor_s = xor_r ^ rx_data;
`endif
          if (idx_r == LAST_IDX) begin
            state_s = ST_MODE;
            idx_s   = '0;
          end else begin
            idx_s   = idx_r + 1'b1;
          end
        end
        ST_MODE: begin
          mode_stage_s = rx_data;
`ifdef RGBW_FRAME_CHECKSUM_EN
          xor_s   = xor_r ^ rx_data;
          state_s = ST_CHECK;
`else
          commit_s = 1'b1;
          state_s  = ST_HUNT;
`endif
        end
`ifdef RGBW_FRAME_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_data == xor_r) begin
            commit_s = 1'b1;
          end else begin
            err_s    = 1'b1;
          end
          state_s = ST_HUNT;
        end
`endif
        default: begin
          state_s = ST_HUNT;
          idx_s   = '0;
        end
      endcase
    end else if (clk_en && (state_r != ST_HUNT)) begin
      if (tmo_r == TMO_LAST) begin
        state_s = ST_HUNT;
        idx_s   = '0;
        tmo_s   = '0;
        err_s   = 1'b1;
      end else begin
        tmo_s   = tmo_r + 1'b1;
      end
    end else begin
      tmo_s = tmo_r;
    end
  end

  // state and bank registers; strobes are cleared on every clk so they last one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_HUNT;
      idx_r         <= '0;
      tmo_r         <= '0;
      stage_r       <= '0;
      mode_stage_r  <= '0;
      ch_out_r      <= '0;
      mode_out_r    <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
`ifdef RGBW_FRAME_CHECKSUM_EN
      xor_r         <= '0;
`endif
    end else begin
      frame_valid_r <= commit_s;
      frame_err_r   <= err_s;
      if (clk_en) begin
        state_r      <= state_s;
        idx_r        <= idx_s;
        tmo_r        <= tmo_s;
        stage_r      <= stage_s;
        mode_stage_r <= mode_stage_s;
        busy_r       <= (state_s != ST_HUNT);
`ifdef RGBW_FRAME_CHECKSUM_EN
        xor_r        <= xor_s;
`endif
        if (commit_s) begin
          ch_out_r   <= stage_s;
          mode_out_r <= mode_stage_s;
        end else begin
          ch_out_r   <= ch_out_r;
          mode_out_r <= mode_out_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign ch_out      = ch_out_r;
  assign mode_out    = mode_out_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Self-checking bench for rgbw_frame_decoder: fixed frame table, corner sequences and
// randomized frames against a stream-level reference parser.
module tb_rgbw_frame_decoder;

  localparam int NCH = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [47:0] ch_out;
  logic [7:0]  mode_out;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  bit en_rand   = 1'b0;

  logic [47:0] exp_ch;
  logic [7:0]  exp_md;

  typedef struct {
    logic [9:0][7:0] w;
    int              n;
    logic [47:0]     ch;
    logic [7:0]      mode;
  } vec_t;

  vec_t vecs [4];

  rgbw_frame_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .ch_out      (ch_out),
    .mode_out    (mode_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (frame_valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_en(input int n);
    int got = 0;
    int spent = 0;
    while (got < n && spent < 1000) begin
      @(posedge clk);
      spent++;
      if (clk_en) got++;
    end
    if (got < n) check("wait_en_budget", 64'(got), 64'(n));
  endtask

  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    rx_data = w;
    rx_rdy  = 1'b1;
    wait_en(4);
    @(negedge clk);
    rx_rdy = 1'b0;
    wait_en(4);
  endtask

  // reference parser: first sync word starts the frame, then channels, mode, optional checksum
  function automatic void model_stream(input logic [7:0] q[$], output bit ok,
                                       output logic [47:0] ch, output logic [7:0] md);
    int s = -1;
    int need;
    logic [7:0] x;
    for (int i = 0; i < q.size(); i++) if (s < 0 && q[i] == 8'h55) s = i;
`ifdef RGBW_FRAME_CHECKSUM_EN
    need = NCH + 3;
`else
    need = NCH + 2;
`endif
    ok = (s >= 0) && (q.size() >= s + need);
    ch = '0;
    md = '0;
    if (ok) begin
      for (int k = 0; k < NCH; k++) ch[k*8 +: 8] = q[s+1+k];
      md = q[s+1+NCH];
`ifdef RGBW_FRAME_CHECKSUM_EN
      x = 8'h00;
      for (int i = s; i <= s + NCH + 1; i++) x = x ^ q[i];
      ok = (x == q[s+NCH+2]);
`else
      x = 8'h00;
`endif
    end
  endfunction

  task automatic check_frame(input string tag, input int v0, input int e0, input bit ok);
    check({tag, "_valid"}, 64'(valid_cnt - v0), ok ? 64'd1 : 64'd0);
    check({tag, "_err"},   64'(err_cnt - e0),   ok ? 64'd0 : 64'd1);
    check({tag, "_ch"},    64'(ch_out),   64'(exp_ch));
    check({tag, "_mode"},  64'(mode_out), 64'(exp_md));
    check({tag, "_busy"},  64'(busy),     64'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] w;
    logic [7:0] x;
    logic [47:0] m_ch;
    logic [7:0]  m_md;
    bit ok;
    int v0, e0;

    vecs[0].w = {8'h00, 8'h00, 8'h03, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h02, 8'h10, 8'h55};
    vecs[0].n = 8;  vecs[0].ch = 48'h20_40_80_FF_02_10; vecs[0].mode = 8'h03;
    vecs[1].w = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h55, 8'hAA, 8'h00};
    vecs[1].n = 10; vecs[1].ch = 48'h06_05_04_03_02_01; vecs[1].mode = 8'h07;
    vecs[2].w = {8'h00, 8'h00, 8'h01, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    vecs[2].n = 8;  vecs[2].ch = 48'h55_55_55_55_55_55; vecs[2].mode = 8'h01;
    vecs[3].w = {8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h55};
    vecs[3].n = 8;  vecs[3].ch = 48'hAA_BB_CC_DD_EE_FF; vecs[3].mode = 8'h00;

    reset   = 1'b1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    exp_ch  = '0;
    exp_md  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ch", 64'(ch_out), 64'd0);
    check("rst_mode", 64'(mode_out), 64'd0);
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // fixed frames, including leading garbage and payload bytes equal to the sync word
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int j = 0; j < vecs[i].n; j++) send_word(vecs[i].w[j]);
`ifdef RGBW_FRAME_CHECKSUM_EN
      x = 8'h00;
      for (int j = vecs[i].n - NCH - 2; j < vecs[i].n; j++) x = x ^ vecs[i].w[j];
      send_word(x);
`endif
      exp_ch = vecs[i].ch;
      exp_md = vecs[i].mode;
      check_frame($sformatf("vec%0d", i), v0, e0, 1'b1);
    end

    // timeout: partial frame then silence
    v0 = valid_cnt;
    e0 = err_cnt;
    send_word(8'h55);
    send_word(8'h10);
    send_word(8'h02);
    check("tmo_busy_mid", 64'(busy), 64'd1);
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check_frame("tmo", v0, e0, 1'b0);

    // gaps just under the timeout must not abort the frame
    v0 = valid_cnt;
    e0 = err_cnt;
    q = {8'h55, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h0A};
`ifdef RGBW_FRAME_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
    foreach (q[i]) begin
      send_word(q[i]);
      repeat (1000) @(posedge clk);
    end
    exp_ch = 48'h76_65_54_43_32_21;
    exp_md = 8'h0A;
    check_frame("gap", v0, e0, 1'b1);

    // reset in the middle of a frame clears outputs immediately
    send_word(8'h55);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ch", 64'(ch_out), 64'd0);
    check("midrst_mode", 64'(mode_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_ch = '0;
    exp_md = '0;
    v0 = valid_cnt;
    e0 = err_cnt;
    q = {8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`ifdef RGBW_FRAME_CHECKSUM_EN
    q.push_back(8'h55);
`endif
    foreach (q[i]) send_word(q[i]);
    exp_ch = 48'h06_05_04_03_02_01;
    exp_md = 8'h07;
    check_frame("postrst", v0, e0, 1'b1);

`ifdef RGBW_FRAME_CHECKSUM_EN
    v0 = valid_cnt;
    e0 = err_cnt;
    q = {8'h55, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'h54};
    foreach (q[i]) send_word(q[i]);
    check_frame("badsum", v0, e0, 1'b0);
`endif

    // randomized frames with leading garbage; odd iterations also randomize clk_en
    for (int f = 0; f < 16; f++) begin
      en_rand = (f % 2 == 1);
      q = {};
      repeat ($urandom_range(0, 2)) begin
        w = 8'($urandom_range(0, 255));
        if (w == 8'h55) w = 8'h54;
        q.push_back(w);
      end
      q.push_back(8'h55);
      repeat (NCH + 1) q.push_back(8'($urandom_range(0, 255)));
`ifdef RGBW_FRAME_CHECKSUM_EN
      x = 8'h00;
      for (int i = q.size() - NCH - 2; i < q.size(); i++) x = x ^ q[i];
      if ($urandom_range(0, 3) == 0) x = x ^ 8'h01;
      q.push_back(x);
`endif
      model_stream(q, ok, m_ch, m_md);
      v0 = valid_cnt;
      e0 = err_cnt;
      foreach (q[i]) send_word(q[i]);
      if (ok) begin
        exp_ch = m_ch;
        exp_md = m_md;
      end
      en_rand = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_frame($sformatf("rnd%0d", f), v0, e0, ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
